// File: rtl/mips_issue_scoreboard.sv
// Register-hazard scoreboard and issue controller between ID and ID/EX.
// Tracks in-flight destination registers, stalls RAW hazards, flushes on taken branch, latches halt.
module mips_issue_scoreboard #(
   parameter int DEPTH       = 3,
   parameter int FLUSH_DEPTH = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk1,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [4:0]       id_rd,
   input  logic             id_writes,
   input  logic             id_halt,
   input  logic             branch_taken,
   output logic             issue,
   output logic             stall,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [DEPTH-1:0]      v_q, v_d;
   logic [DEPTH-1:0][4:0] rd_q, rd_d;
   logic                  halted_q, halted_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  rs_hit_s, rt_hit_s;
   logic                  rs_match_s, rt_match_s;

   // Source-versus-in-flight comparison; R0 is never a hazard
   always_comb begin
      rs_hit_s = 1'b0;
      rt_hit_s = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (v_q[k] && (rd_q[k] == id_rs)) begin
            rs_hit_s = 1'b1;
         end else begin
            rs_hit_s = rs_hit_s;
         end
         if (v_q[k] && (rd_q[k] == id_rt)) begin
            rt_hit_s = 1'b1;
         end else begin
            rt_hit_s = rt_hit_s;
         end
      end
      rs_match_s = id_uses_rs & (id_rs != 5'd0) & rs_hit_s;
      rt_match_s = id_uses_rt & (id_rt != 5'd0) & rt_hit_s;
   end

   // Zero-latency issue decision; a taken branch kills the ID instruction outright
   always_comb begin
      stall = rst_n & id_valid & (rs_match_s | rt_match_s | halted_q) & ~branch_taken;
      issue = rst_n & id_valid & ~stall & ~branch_taken;
   end

   // Next state: shift toward WB, load entry 0, flush the youngest entries on a branch
   always_comb begin
      v_d     = '0;
      rd_d    = '0;
      v_d[0]  = issue & id_writes & (id_rd != 5'd0);
      rd_d[0] = issue ? id_rd : 5'd0;
      for (int k = 1; k < DEPTH; k++) begin
         v_d[k]  = v_q[k-1];
         rd_d[k] = rd_q[k-1];
      end
      if (branch_taken) begin
         for (int k = 0; k < FLUSH_DEPTH; k++) begin
            v_d[k] = 1'b0;
         end
      end else begin
         v_d = v_d;
      end
      halted_d = halted_q | (issue & id_halt);
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         v_q      <= '0;
         rd_q     <= '0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         v_q      <= v_d;
         rd_q     <= rd_d;
         halted_q <= halted_d;
         cnt_q    <= cnt_d;
      end
   end

   assign halted    = halted_q;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_mips_issue_scoreboard.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
// A second instance with a 4-bit counter shares the stimulus to check saturation.
module tb_mips_issue_scoreboard;

   logic        clk1 = 1'b0;
   logic        rst_n;
   logic        id_valid, id_uses_rs, id_uses_rt, id_writes, id_halt, branch_taken;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        issue, stall, halted;
   logic [15:0] stall_cnt;
   logic        s_issue, s_stall, s_halted;
   logic [3:0]  s_cnt;

   typedef struct packed {
      logic        iss;
      logic        stl;
      logic        hlt;
      logic [15:0] cnt;
      logic [3:0]  cnt4;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   exp_t  cur_e;
   string cur_n;
   int    n_checks = 0;
   int    n_fail   = 0;
   int    mc = 0;
   logic  mh = 1'b0;

   always #5 clk1 = ~clk1;

   mips_issue_scoreboard u_dut (
      .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_writes(id_writes),
      .id_halt(id_halt), .branch_taken(branch_taken), .issue(issue), .stall(stall),
      .halted(halted), .stall_cnt(stall_cnt)
   );

   mips_issue_scoreboard #(.CNT_W(4)) u_sat (
      .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_writes(id_writes),
      .id_halt(id_halt), .branch_taken(branch_taken), .issue(s_issue), .stall(s_stall),
      .halted(s_halted), .stall_cnt(s_cnt)
   );

   task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
      end
   endtask

   // Monitor: outputs are valid every cycle, compared half a period after the drive
   always @(negedge clk1) begin
      if (exp_q.size() > 0) begin
         cur_e = exp_q.pop_front();
         cur_n = name_q.pop_front();
         chk(cur_n, "issue",    {15'd0, issue},    {15'd0, cur_e.iss});
         chk(cur_n, "stall",    {15'd0, stall},    {15'd0, cur_e.stl});
         chk(cur_n, "halted",   {15'd0, halted},   {15'd0, cur_e.hlt});
         chk(cur_n, "stall_cnt", stall_cnt,        cur_e.cnt);
         chk(cur_n, "sat_issue", {15'd0, s_issue}, {15'd0, cur_e.iss});
         chk(cur_n, "sat_stall", {15'd0, s_stall}, {15'd0, cur_e.stl});
         chk(cur_n, "sat_cnt",   {12'd0, s_cnt},   {12'd0, cur_e.cnt4});
      end
   end

   task automatic step(input logic rst, input logic v,
                       input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt,
                       input logic [4:0] rd, input logic wr, input logic hlt, input logic br,
                       input logic e_iss, input logic e_stl, input string nm);
      exp_t e;
      rst_n = rst; id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
      id_rd = rd; id_writes = wr; id_halt = hlt; branch_taken = br;
      e.iss  = e_iss;
      e.stl  = e_stl;
      e.hlt  = mh;
      e.cnt  = mc[15:0];
      e.cnt4 = (mc > 15) ? 4'd15 : mc[3:0];
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk1);
      #1;
      if (!rst) begin
         mc = 0;
         mh = 1'b0;
      end else begin
         if (e_stl) mc++;
         if (e_iss && hlt) mh = 1'b1;
      end
   endtask

   initial begin
      rst_n = 1'b0; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0;
      id_uses_rt = 1'b0; id_rd = 5'd0; id_writes = 1'b0; id_halt = 1'b0; branch_taken = 1'b0;
      repeat (2) @(posedge clk1);
      #1;
      //   rst v  rs    urs rt    urt rd     wr hlt br  iss stl
      step(0, 1, 5'd1, 1, 5'd2, 1, 5'd3,  1, 0, 0,  0,  0, "rst_force");
      step(1, 0, 5'd0, 0, 5'd0, 0, 5'd0,  0, 0, 0,  0,  0, "idle");
      step(1, 1, 5'd0, 1, 5'd0, 0, 5'd1,  1, 0, 0,  1,  0, "addi_r1");
      for (int i = 0; i < 3; i++)
         step(1, 1, 5'd1, 1, 5'd2, 1, 5'd4, 1, 0, 0, 0, 1, "raw1_stall");
      step(1, 1, 5'd1, 1, 5'd2, 1, 5'd4,  1, 0, 0,  1,  0, "raw1_issue");
      step(1, 1, 5'd0, 1, 5'd0, 0, 5'd1,  1, 0, 0,  1,  0, "addi_r1_b");
      step(1, 1, 5'd7, 1, 5'd7, 1, 5'd7,  1, 0, 0,  1,  0, "or_r7");
      step(1, 1, 5'd8, 1, 5'd8, 1, 5'd8,  1, 0, 0,  1,  0, "or_r8");
      step(1, 1, 5'd1, 1, 5'd2, 1, 5'd4,  1, 0, 0,  0,  1, "raw3_stall");
      step(1, 1, 5'd1, 1, 5'd2, 1, 5'd4,  1, 0, 0,  1,  0, "raw3_issue");
      step(1, 1, 5'd0, 1, 5'd0, 0, 5'd0,  1, 0, 0,  1,  0, "write_r0");
      step(1, 1, 5'd0, 1, 5'd0, 1, 5'd9,  1, 0, 0,  1,  0, "read_r0");
      step(1, 1, 5'd0, 1, 5'd0, 0, 5'd5,  1, 0, 0,  1,  0, "addi_r5");
      step(1, 1, 5'd5, 1, 5'd5, 1, 5'd6,  1, 0, 1,  0,  0, "branch_kill");
      step(1, 1, 5'd9, 1, 5'd9, 1, 5'd10, 1, 0, 0,  0,  1, "older_survive");
      step(1, 1, 5'd5, 1, 5'd5, 1, 5'd6,  1, 0, 0,  1,  0, "flushed_r5");
      for (int i = 0; i < 3; i++)
         step(1, 1, 5'd6, 1, 5'd0, 0, 5'd0, 0, 1, 0, 0, 1, "hlt_dep_stall");
      step(1, 1, 5'd6, 1, 5'd0, 0, 5'd0,  0, 1, 0,  1,  0, "hlt_issue");
      for (int i = 0; i < 14; i++)
         step(1, 1, 5'd0, 1, 5'd0, 0, 5'd11, 1, 0, 0, 0, 1, "halted_stall");
      step(1, 0, 5'd0, 1, 5'd0, 0, 5'd11, 1, 0, 0,  0,  0, "halted_idle");
      step(1, 1, 5'd0, 1, 5'd0, 0, 5'd11, 1, 0, 1,  0,  0, "halted_branch");
      step(0, 1, 5'd0, 1, 5'd0, 0, 5'd11, 1, 0, 0,  0,  0, "rst_mid");
      step(1, 1, 5'd0, 1, 5'd0, 0, 5'd12, 1, 0, 0,  1,  0, "after_rst");
      step(0, 1, 5'd12, 1, 5'd0, 0, 5'd13, 1, 0, 0, 0,  0, "rst_flush");
      step(1, 1, 5'd12, 1, 5'd0, 0, 5'd13, 1, 0, 0, 1,  0, "rst_cleared");
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_issue_scoreboard.md
# mips_issue_scoreboard

Register-hazard scoreboard and issue controller for the MIPS pipeline. It sits between the ID stage and the ID/EX latch and tracks destination registers still in flight through EX, MEM and WB. It stalls dependent instructions until their source registers are written back, which removes the need for hand-placed dummy `OR R7,R7,R7` instructions in test programs. It also squashes in-flight writes on a taken branch, latches the halt condition and counts stall cycles.

## Interface
- `DEPTH`, 3: in-flight stages tracked after ID (EX, MEM, WB); entry k corresponds to stage k+1.
- `FLUSH_DEPTH`, 2: number of youngest entries a taken branch kills (≤ DEPTH).
- `CNT_W`, 16: stall counter width.
- `clk1` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `id_valid` in 1: ID holds a decoded instruction.
- `id_rs`, `id_rt` in 5 each: source register numbers.
- `id_uses_rs`, `id_uses_rt` in 1 each: instruction reads that source.
- `id_rd` in 5: destination register number.
- `id_writes` in 1: instruction writes `id_rd`.
- `id_halt` in 1: instruction is HLT.
- `branch_taken` in 1: taken branch resolved this cycle; kill younger work.
- `issue` out 1: ID instruction is accepted into EX this cycle.
- `stall` out 1: hold PC and IF/ID this cycle.
- `halted` out 1: sticky; HLT has issued.
- `stall_cnt` out CNT_W: saturating count of stall cycles.

## Operation
- State:
  - Shift register of DEPTH entries `{v, rd}`.
  - `halted` flag.
  - `stall_cnt`.
- Every cycle, entries shift one position toward WB unconditionally. Entry DEPTH-1 retires; its register write is readable by ID in the following cycle. No bypass.
- Hazard match:
  - A source matches when its use bit is set, it is nonzero, and any entry has v=1 with rd equal to that source.
  - R0 never matches and is never recorded: an entry is recorded with v=0 when `id_rd`=0.
- `stall` = `id_valid` & (rs match | rt match | `halted`) & ~`branch_taken`.
- `issue` = `id_valid` & ~`stall` & ~`branch_taken`.
- Entry 0 load:
  - On `issue`, load `{id_writes & (id_rd≠0), id_rd}`.
  - Otherwise load a bubble with v=0.
- `branch_taken`:
  - Clears v of the entries that would occupy positions 0..FLUSH_DEPTH-1 after the shift.
  - The ID instruction is killed (not issued, not stalled).
  - Older entries continue and retire normally.
- Halt:
  - Issuing with `id_halt`=1 sets `halted` on the next edge.
  - Afterwards every valid ID instruction stalls.
  - In-flight entries still drain.
  - Only reset clears `halted`.
- `stall_cnt` increments on each cycle `stall`=1 and saturates at all-ones.

## Timing
- Reset (`rst_n`=0 at an edge):
  - All v=0, `halted`=0, `stall_cnt`=0.
  - While `rst_n`=0, `issue` and `stall` are forced 0.
  - Reset mid-operation discards all in-flight entries.
- `issue` and `stall` are combinational from ID inputs and registered state: zero-cycle decision, no added latency for independent instructions.
- Dependent back-to-back instruction (RAW distance 1): stalls exactly DEPTH cycles and issues on cycle DEPTH+1 after the producer issued. Distance d issues with max(0, DEPTH+1-d) stall cycles.
- Same register in rs and rt is treated as a single hazard.
- `branch_taken` together with a stall condition: the kill takes priority and `stall`=0.
- HLT dependent on an in-flight write stalls like any other instruction. `halted` is set only once HLT issues.

## Test plan
- After reset: `issue`=0, `stall`=0, `halted`=0, `stall_cnt`=0. Release reset with `id_valid`=0 → all outputs remain 0.
- Issue ADDI R1,R0,10, then ADD R4,R1,R2 next cycle → `stall`=1 for 3 cycles, `issue`=1 on the 4th, `stall_cnt`=3.
- Issue ADDI R1, two independent ORs, then ADD R4,R1,R2 → 1 stall cycle. Writing R0, then reading R0 → no stall.
- Issue ADDI R5, then assert `branch_taken` next cycle while ADD R6,R5,R5 is in ID → ADD killed (`issue`=0, `stall`=0). Re-presenting ADD R6,R5,R5 next cycle → no stall, since the R5 entry was flushed.
- Issue HLT → `halted`=1 next cycle; subsequent valid instructions stall indefinitely. Assert `rst_n`=0 for one edge → `halted`=0 and `stall_cnt`=0.
- Set CNT_W=4 and hold a dependency against a perpetually halted ID → `stall_cnt` saturates at 15.
